// File: rtl/button_pulse_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : button_pulse_array                                              |
// | Brief  : Sync + debounce per push-button, then a shared press arbiter    |
// |          that emits one command pulse per press. Build option            |
// |          AUTO_REPEAT_EN adds hold-to-repeat on non-priority channels.    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module button_pulse_array #(
  parameter int NUM_BTN       = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 4,
  parameter int PRIO_IDX      = 2,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic               enable,
  output logic [NUM_BTN-1:0] pulse_out,
  output logic [NUM_BTN-1:0] level_out,
  output logic               held
);

  localparam int                 c_CntW     = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [c_CntW-1:0]  c_CntLast  = c_CntW'(DEBOUNCE_CYC - 1);
  localparam logic [NUM_BTN-1:0] c_PrioMask = NUM_BTN'(1) << PRIO_IDX;
  localparam logic [0:0]         c_IDLE     = 1'b0;
  localparam logic [0:0]         c_HELD     = 1'b1;

  logic [NUM_BTN-1:0] r_sync [SYNC_STAGES];
  logic [0:0]         r_state;
  logic [0:0]         w_nextState;
  logic [NUM_BTN-1:0] r_pulse;
  logic [NUM_BTN-1:0] w_pulseNext;
  logic [NUM_BTN-1:0] w_pressPulse;
  logic [NUM_BTN-1:0] w_others;
  logic               w_othersOne;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= btn_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // The level only flips after DEBOUNCE_CYC consecutive disagreeing samples.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic [c_CntW-1:0] r_cnt;
    logic              r_level;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (r_sync[SYNC_STAGES-1][i] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CntLast) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_CntW'(1);
      end
    end

    assign level_out[i] = r_level;
  end

  assign w_others    = level_out & ~c_PrioMask;
  assign w_othersOne = (w_others != '0) && ((w_others & (w_others - NUM_BTN'(1))) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_pulse <= '0;
    end else begin
      r_state <= w_nextState;
      r_pulse <= w_pulseNext;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (|level_out)  w_nextState = c_HELD;
      c_HELD:  if (~|level_out) w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  // Ambiguous multi-press (no priority bit) and presses under enable=0 give no pulse.
  always_comb begin
    w_pressPulse = '0;
    if (r_state == c_IDLE && enable) begin
      if (level_out[PRIO_IDX]) w_pressPulse = c_PrioMask;
      else if (w_othersOne)    w_pressPulse = w_others;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [15:0] c_RepFirst = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] c_RepNext  = 16'(REPEAT_DELAY - 1 + REPEAT_PERIOD);
  localparam logic [15:0] c_RepReload = 16'(REPEAT_DELAY);

  logic [NUM_BTN-1:0] r_repeatMask;
  logic [15:0]        r_repCnt;
  logic               w_repeatRun;
  logic               w_repeatFire;

  assign w_repeatRun  = (r_state == c_HELD) && enable && (r_repeatMask != '0) &&
                        (level_out == r_repeatMask);
  assign w_repeatFire = w_repeatRun && (r_repCnt == c_RepFirst || r_repCnt == c_RepNext);

  // The mask remembers which non-priority press pulsed; any change to the held set forfeits it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_repeatMask <= '0;
      r_repCnt     <= '0;
    end else begin
      if (r_state == c_IDLE)             r_repeatMask <= w_pressPulse & ~c_PrioMask;
      else if (level_out != r_repeatMask) r_repeatMask <= '0;

      if (!w_repeatRun)      r_repCnt <= '0;
      else if (w_repeatFire) r_repCnt <= c_RepReload;
      else                   r_repCnt <= r_repCnt + 16'd1;
    end
  end

  always_comb begin
    w_pulseNext = w_pressPulse;
    if (w_repeatFire) w_pulseNext = r_repeatMask;
  end
`else
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeatParamRange
  end

  always_comb begin
    w_pulseNext = w_pressPulse;
  end
`endif

  assign pulse_out = r_pulse;
  assign held      = (r_state == c_HELD);

endmodule
`default_nettype wire
